// File: rtl/tiny16_intc_pkg.sv
// rtl/tiny16_intc_pkg.sv - shared constants, FSM encoding and helpers for tiny16_intc
//
// Purpose : register window offsets, default base address, source count,
//           FSM state encoding and the fixed-priority encoder used by the
//           interrupt controller and its sub-module.
// Ports   : none (package).

package tiny16_intc_pkg;

    localparam logic [15:0] DEFAULT_BASE = 16'hFF00;
    localparam int          IRQ_LINES    = 8;

    // Word offsets inside the 4-word register window.
    localparam logic [1:0] OFS_PENDING = 2'd0;
    localparam logic [1:0] OFS_MASK    = 2'd1;
    localparam logic [1:0] OFS_CAUSE   = 2'd2;
    localparam logic [1:0] OFS_MODE    = 2'd3;

    // Request FSM; plain vector constants keep the encoding visible in
    // waveforms and compatible with older tooling.
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Index of the lowest set bit; bit 0 is the highest priority source.
    // Returns 0 for an all-zero vector, callers qualify with a non-zero test.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                id = 3'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/tiny16_intc_if.sv
// rtl/tiny16_intc_if.sv - CPU register bus between the CPU and tiny16_intc
//
// Purpose : groups the CPU-side register access signals.
// Signals : address  - CPU bus address
//           data_in  - CPU write data (CPU data_out)
//           rd       - read strobe, active-low
//           wr       - write strobe, active-low
//           data_out - register read data, 0 when not selected for read
//           sel      - 1 when address falls in the register window
// Modports: master (CPU side), slave (interrupt controller side).

interface tiny16_intc_if;

    logic [15:0] address;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        sel;

    modport master (
        output address,
        output data_in,
        output rd,
        output wr,
        input  data_out,
        input  sel
    );

    modport slave (
        input  address,
        input  data_in,
        input  rd,
        input  wr,
        output data_out,
        output sel
    );

endinterface

// File: rtl/tiny16_irq_sync.sv
// rtl/tiny16_irq_sync.sv - per-line 2-flop synchronizer plus rising-edge detector
//
// Purpose : brings one asynchronous interrupt line into the clk domain and
//           flags a synchronized 0->1 transition for one cycle.
// Ports   : clk       - system clock
//           reset     - synchronous, active-high reset
//           irq_async - raw asynchronous interrupt line
//           level     - synchronized level (second synchronizer flop)
//           rise      - 1 for one cycle after a synchronized 0->1 transition

module tiny16_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    output logic level,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= irq_async;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~dly_q;

endmodule

// File: rtl/tiny16_intc.sv
// rtl/tiny16_intc.sv - 8-source prioritized interrupt controller for the tiny16 CPU
//
// Purpose : synchronizes 8 interrupt lines, latches them in PENDING
//           (edge or level per MODE), gates them with MASK and drives a
//           registered request to the CPU through an IDLE/REQ/SERVICE FSM.
//           CAUSE reports the winning source while it is being serviced.
// Ports   : clk          - system clock
//           reset        - synchronous, active-high reset
//           irq          - asynchronous interrupt sources, bit 0 highest priority
//           bus          - CPU register bus (slave side): address, data_in,
//                          rd, wr in; data_out, sel out
//           interrupt    - registered interrupt request to the CPU
//           in_interrupt - CPU in-service flag
// Registers (word offset from BASE):
//           0 PENDING W1C, 1 MASK RW, 2 CAUSE RO {valid,12'b0,id}, 3 MODE RW

module tiny16_intc
    import tiny16_intc_pkg::*;
#(
    parameter logic [15:0] BASE      = DEFAULT_BASE,
    parameter int          IRQ_COUNT = IRQ_LINES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IRQ_COUNT-1:0] irq,
    tiny16_intc_if.slave         bus,
    output logic                 interrupt,
    input  logic                 in_interrupt
);

    logic [IRQ_COUNT-1:0] irq_level;
    logic [IRQ_COUNT-1:0] irq_rise;

    logic [IRQ_COUNT-1:0] pending;
    logic [IRQ_COUNT-1:0] pending_d;
    logic [IRQ_COUNT-1:0] mask;
    logic [IRQ_COUNT-1:0] mode;
    logic                 cause_valid;
    logic [2:0]           cause_id;

    state_t               state;
    logic                 in_int_q;

    logic [15:0]          ofs;
    logic [1:0]           reg_idx;
    logic                 we;
    logic                 re;

    logic [IRQ_COUNT-1:0] w1c;
    logic [IRQ_COUNT-1:0] mode_chg;
    logic [IRQ_COUNT-1:0] pm;
    logic [2:0]           win_id;
    logic                 in_rise;
    logic                 in_fall;
    logic                 enter_service;
    logic [IRQ_COUNT-1:0] svc_clr;

    logic                 unused_data_hi;

    for (genvar i = 0; i < IRQ_COUNT; i++) begin : g_sync
        tiny16_irq_sync u_sync (
            .clk       (clk),
            .reset     (reset),
            .irq_async (irq[i]),
            .level     (irq_level[i]),
            .rise      (irq_rise[i])
        );
    end

    // Subtracting BASE first lets an unaligned BASE decode correctly.
    assign ofs     = bus.address - BASE;
    assign bus.sel = (ofs[15:2] == 14'd0);
    assign reg_idx = ofs[1:0];
    assign we      = ~bus.wr & bus.sel;
    assign re      = ~bus.rd & bus.sel;

    assign unused_data_hi = ^bus.data_in[15:IRQ_COUNT];

    always_comb begin
        bus.data_out = 16'h0000;
        if (re) begin
            case (reg_idx)
                OFS_PENDING: bus.data_out = {{(16-IRQ_COUNT){1'b0}}, pending};
                OFS_MASK:    bus.data_out = {{(16-IRQ_COUNT){1'b0}}, mask};
                OFS_CAUSE:   bus.data_out = {cause_valid, 12'd0, cause_id};
                OFS_MODE:    bus.data_out = {{(16-IRQ_COUNT){1'b0}}, mode};
                default:     bus.data_out = 16'h0000;
            endcase
        end
    end

    always_comb begin
        w1c      = '0;
        mode_chg = '0;
        if (we && reg_idx == OFS_PENDING) begin
            w1c = bus.data_in[IRQ_COUNT-1:0];
        end
        if (we && reg_idx == OFS_MODE) begin
            mode_chg = bus.data_in[IRQ_COUNT-1:0] ^ mode;
        end
    end

    assign pm            = pending & mask;
    assign win_id        = lowest_set(pm);
    assign in_rise       = in_interrupt & ~in_int_q;
    assign in_fall       = ~in_interrupt & in_int_q;
    assign enter_service = (state == ST_REQ) && in_rise && (pm != '0);
    assign svc_clr       = enter_service ? ({{(IRQ_COUNT-1){1'b0}}, 1'b1} << win_id) : '0;

    // Per-bit PENDING update. A MODE change discards stale state for that
    // line; in edge mode a fresh edge beats any clear in the same cycle;
    // in level mode the bit simply mirrors the synchronized line.
    always_comb begin
        pending_d = pending;
        for (int i = 0; i < IRQ_COUNT; i++) begin
            if (mode_chg[i]) begin
                pending_d[i] = 1'b0;
            end else if (mode[i]) begin
                if (irq_rise[i]) begin
                    pending_d[i] = 1'b1;
                end else if (svc_clr[i] || w1c[i]) begin
                    pending_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = irq_level[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
        end else begin
            pending <= pending_d;
            if (we && reg_idx == OFS_MASK) begin
                mask <= bus.data_in[IRQ_COUNT-1:0];
            end
            if (we && reg_idx == OFS_MODE) begin
                mode <= bus.data_in[IRQ_COUNT-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            interrupt   <= 1'b0;
            cause_valid <= 1'b0;
            cause_id    <= 3'd0;
            in_int_q    <= 1'b0;
        end else begin
            in_int_q <= in_interrupt;
            case (state)
                ST_IDLE: begin
                    if (pm != '0) begin
                        state     <= ST_REQ;
                        interrupt <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Request withdrawn (masked or cleared) before the CPU took it.
                    if (pm == '0) begin
                        state     <= ST_IDLE;
                        interrupt <= 1'b0;
                    end else if (in_rise) begin
                        state       <= ST_SERVICE;
                        interrupt   <= 1'b0;
                        cause_valid <= 1'b1;
                        cause_id    <= win_id;
                    end
                end
                ST_SERVICE: begin
                    // Returning to IDLE first guarantees at least one idle
                    // cycle before the next request is raised.
                    if (in_fall) begin
                        state       <= ST_IDLE;
                        cause_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tiny16_intc.sv
// tb/tb_tiny16_intc.sv - scoreboard testbench for tiny16_intc

module tb_tiny16_intc;
    import tiny16_intc_pkg::*;

    localparam logic [15:0] BASE = DEFAULT_BASE;

    logic       clk;
    logic       reset;
    logic [7:0] irq;
    logic       interrupt;
    logic       in_interrupt;

    tiny16_intc_if bus();

    tiny16_intc #(
        .BASE      (BASE),
        .IRQ_COUNT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .bus          (bus),
        .interrupt    (interrupt),
        .in_interrupt (in_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] data;
        logic        sel;
        logic        chk_int;
        logic        intr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: every read cycle the DUT presents is matched against the
    // oldest expectation pushed by the stimulus.
    always @(negedge clk) begin
        if (bus.rd === 1'b0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: data_out=%h with no expectation queued", bus.data_out);
            end else begin
                mon_e = sb.pop_front();
                n_checks++;
                if (bus.data_out !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL %s data_out: got %h required %h", mon_e.tag, bus.data_out, mon_e.data);
                end
                n_checks++;
                if (bus.sel !== mon_e.sel) begin
                    n_fail++;
                    $display("FAIL %s sel: got %b required %b", mon_e.tag, bus.sel, mon_e.sel);
                end
                if (mon_e.chk_int) begin
                    n_checks++;
                    if (interrupt !== mon_e.intr) begin
                        n_fail++;
                        $display("FAIL %s interrupt: got %b required %b", mon_e.tag, interrupt, mon_e.intr);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, %0d expectations pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] ofs, input logic [15:0] val);
        bus.address = BASE + {14'd0, ofs};
        bus.data_in = val;
        bus.wr      = 1'b0;
        tick();
        bus.wr      = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] data,
                          input logic sel, input logic chk_int, input logic intr);
        exp_t e;
        e.tag     = tag;
        e.data    = data;
        e.sel     = sel;
        e.chk_int = chk_int;
        e.intr    = intr;
        sb.push_back(e);
        bus.address = addr;
        bus.rd      = 1'b0;
        tick();
        bus.rd      = 1'b1;
    endtask

    task automatic rd_reg(input string tag, input logic [1:0] ofs, input logic [15:0] data,
                          input logic intr);
        rd_chk(tag, BASE + {14'd0, ofs}, data, 1'b1, 1'b1, intr);
    endtask

    initial begin
        reset        = 1'b1;
        irq          = 8'h00;
        in_interrupt = 1'b0;
        bus.address  = 16'h0000;
        bus.data_in  = 16'h0000;
        bus.rd       = 1'b1;
        bus.wr       = 1'b1;
        tick();
        tick();

        // Reset state
        rd_reg("rst_pending", OFS_PENDING, 16'h0000, 1'b0);
        reset = 1'b0;
        rd_reg("rst_mask",  OFS_MASK,  16'h0000, 1'b0);
        rd_reg("rst_cause", OFS_CAUSE, 16'h0000, 1'b0);
        rd_reg("rst_mode",  OFS_MODE,  16'h0000, 1'b0);

        // Single edge source: latency and service entry
        wr_reg(OFS_MASK, 16'h0001);
        wr_reg(OFS_MODE, 16'h0001);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        rd_reg("t1_pend_k",   OFS_PENDING, 16'h0000, 1'b0);
        rd_reg("t1_pend_k1",  OFS_PENDING, 16'h0000, 1'b0);
        rd_reg("t1_pend_k2",  OFS_PENDING, 16'h0001, 1'b0);
        rd_reg("t1_int_k3",   OFS_PENDING, 16'h0001, 1'b1);
        in_interrupt = 1'b1;
        tick();
        rd_reg("t1_cause",    OFS_CAUSE,   16'h8000, 1'b0);
        rd_reg("t1_pend_clr", OFS_PENDING, 16'h0000, 1'b0);
        in_interrupt = 1'b0;
        tick();
        rd_reg("t1_cause_done", OFS_CAUSE, 16'h0000, 1'b0);

        // Two simultaneous edges: priority and re-request after service
        wr_reg(OFS_MASK, 16'h00FF);
        wr_reg(OFS_MODE, 16'h00FF);
        irq = 8'h24;
        tick();
        tick();
        tick();
        rd_reg("t2_pend", OFS_PENDING, 16'h0024, 1'b0);
        rd_reg("t2_int",  OFS_PENDING, 16'h0024, 1'b1);
        in_interrupt = 1'b1;
        tick();
        rd_reg("t2_cause1",    OFS_CAUSE,   16'h8002, 1'b0);
        rd_reg("t2_pend_left", OFS_PENDING, 16'h0020, 1'b0);
        in_interrupt = 1'b0;
        tick();
        rd_reg("t2_gap",   OFS_PENDING, 16'h0020, 1'b0);
        rd_reg("t2_rearm", OFS_PENDING, 16'h0020, 1'b1);
        in_interrupt = 1'b1;
        tick();
        rd_reg("t2_cause2", OFS_CAUSE, 16'h8005, 1'b0);
        in_interrupt = 1'b0;
        irq = 8'h00;
        tick();
        tick();
        tick();
        rd_reg("t2_pend_empty", OFS_PENDING, 16'h0000, 1'b0);

        // Edge wins over a same-cycle W1C; a later W1C clears
        wr_reg(OFS_MASK, 16'h0000);
        irq = 8'h02;
        tick();
        tick();
        wr_reg(OFS_PENDING, 16'h0002);
        rd_reg("t3_set_wins", OFS_PENDING, 16'h0002, 1'b0);
        wr_reg(OFS_PENDING, 16'h0002);
        rd_reg("t3_w1c", OFS_PENDING, 16'h0000, 1'b0);

        // MODE change clears the affected PENDING bit
        irq = 8'h00;
        wr_reg(OFS_MODE, 16'h0000);
        tick();
        tick();
        tick();
        rd_reg("t4_pend_idle", OFS_PENDING, 16'h0000, 1'b0);
        irq = 8'h40;
        tick();
        tick();
        tick();
        rd_reg("t5_level_pend", OFS_PENDING, 16'h0040, 1'b0);
        wr_reg(OFS_MODE, 16'h0040);
        rd_reg("t5_mode_clr", OFS_PENDING, 16'h0000, 1'b0);
        irq = 8'h00;
        wr_reg(OFS_MODE, 16'h0000);
        tick();
        tick();
        tick();

        // Level source: W1C ignored, request withdrawn when line drops
        wr_reg(OFS_MASK, 16'h0008);
        irq = 8'h08;
        tick();
        tick();
        tick();
        tick();
        rd_reg("t6_level_int", OFS_PENDING, 16'h0008, 1'b1);
        wr_reg(OFS_PENDING, 16'h0008);
        rd_reg("t6_w1c_ignored", OFS_PENDING, 16'h0008, 1'b1);
        irq = 8'h00;
        tick();
        tick();
        tick();
        tick();
        rd_reg("t6_drop", OFS_PENDING, 16'h0000, 1'b0);

        // Masking in REQ withdraws the request; reset during SERVICE
        wr_reg(OFS_MODE, 16'h0001);
        wr_reg(OFS_MASK, 16'h0001);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        tick();
        tick();
        tick();
        wr_reg(OFS_MASK, 16'h0000);
        rd_reg("t7_mask_same", OFS_PENDING, 16'h0001, 1'b1);
        rd_reg("t7_mask_drop", OFS_PENDING, 16'h0001, 1'b0);
        wr_reg(OFS_MASK, 16'h0001);
        tick();
        rd_reg("t7_rearm", OFS_PENDING, 16'h0001, 1'b1);
        in_interrupt = 1'b1;
        tick();
        rd_reg("t7_service", OFS_CAUSE, 16'h8000, 1'b0);
        reset = 1'b1;
        tick();
        in_interrupt = 1'b0;
        rd_reg("t7_rst_pend",  OFS_PENDING, 16'h0000, 1'b0);
        rd_reg("t7_rst_cause", OFS_CAUSE,   16'h0000, 1'b0);
        reset = 1'b0;
        rd_reg("t7_rst_mask", OFS_MASK, 16'h0000, 1'b0);
        rd_reg("t7_rst_mode", OFS_MODE, 16'h0000, 1'b0);
        tick();
        tick();
        rd_reg("t7_no_retained", OFS_PENDING, 16'h0000, 1'b0);

        // Reset while in REQ drops interrupt at that edge
        wr_reg(OFS_MODE, 16'h0001);
        wr_reg(OFS_MASK, 16'h0001);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        tick();
        tick();
        tick();
        rd_reg("t9_req", OFS_CAUSE, 16'h0000, 1'b1);
        reset = 1'b1;
        tick();
        rd_reg("t9_rst_int", OFS_PENDING, 16'h0000, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        rd_reg("t9_idle", OFS_PENDING, 16'h0000, 1'b0);

        // Address decode and upper-bit masking
        rd_chk("t8_above_window", BASE + 16'd4, 16'h0000, 1'b0, 1'b0, 1'b0);
        rd_chk("t8_below_window", BASE - 16'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
        wr_reg(OFS_MASK, 16'hABCD);
        rd_reg("t8_mask_hi_zero", OFS_MASK, 16'h00CD, 1'b0);
        wr_reg(OFS_MODE, 16'hFFFF);
        rd_reg("t8_mode_hi_zero", OFS_MODE, 16'h00FF, 1'b0);

        tick();
        tick();
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tiny16_intc.md
TINY16_INTC -- requirements
Module: tiny16_intc

Interface
REQ-001 Parameter BASE, default 16'hFF00, is the base address of the 4-word register window (BASE..BASE+3).
REQ-002 Parameter IRQ_COUNT, fixed at 8, is the number of interrupt source lines.
REQ-003 clk  in  1  single system clock; all state changes on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 irq  in  8  asynchronous interrupt sources; bit 0 has the highest priority.
REQ-006 address  in  16  CPU bus address.
REQ-007 data_in  in  16  CPU write data (driven from CPU data_out).
REQ-008 rd  in  1  CPU read strobe, active-low.
REQ-009 wr  in  1  CPU write strobe, active-low.
REQ-010 data_out  out  16  register read data; 0 when not selected for read.
REQ-011 sel  out  1  combinational; 1 when address is in BASE..BASE+3, for the bus read mux.
REQ-012 interrupt  out  1  registered request to the CPU interrupt input.
REQ-013 in_interrupt  in  1  CPU in-service flag, registered by the CPU.

Function
REQ-014 Each irq line SHALL pass through a 2-flop synchronizer followed by a delay flop used for edge detection.
REQ-015 Registers (word offset from BASE):
- 0 PENDING[7:0]: read; write-1-to-clear.
- 1 MASK[7:0]: read/write; 1 = enabled.
- 2 CAUSE: bit15 valid, [2:0] source id; read-only.
- 3 MODE[7:0]: read/write; 1 = rising-edge, 0 = level.
- Bits [15:8] of PENDING, MASK and MODE SHALL read 0.
REQ-016 Writes SHALL take effect on every posedge where wr==0 and sel==1; repeated identical writes SHALL be idempotent.
REQ-017 data_out SHALL be combinational: the selected register when rd==0 and sel==1, else 16'h0000.
REQ-018 Edge-mode source: a synchronized 0->1 transition SHALL set its PENDING bit, with set priority over a same-cycle W1C clear.
REQ-019 Level-mode source: the PENDING bit SHALL track the synchronized level; W1C SHALL have no effect on it.
REQ-020 Latency: for an edge-mode source, irq rising before posedge k SHALL set PENDING at posedge k+2 and, when the FSM is in IDLE with MASK set, SHALL assert interrupt at posedge k+3.
REQ-021 The FSM SHALL have three states: IDLE, REQ and SERVICE.
- IDLE->REQ when (PENDING & MASK) != 0; interrupt=1 from that posedge.
- REQ->IDLE when (PENDING & MASK) becomes 0 (masked or cleared) before in_interrupt rises; interrupt=0.
- REQ->SERVICE on in_interrupt 0->1; interrupt=0.
- SERVICE->IDLE on in_interrupt 1->0.
REQ-022 On REQ->SERVICE, CAUSE SHALL latch valid=1 and the lowest-index set bit of PENDING&MASK; for an edge-mode winner, that PENDING bit SHALL clear in the same cycle.
REQ-023 Edges arriving during SERVICE SHALL latch in PENDING, and interrupt SHALL re-assert no earlier than 1 cycle after the return to IDLE.
REQ-024 CAUSE valid SHALL clear on the SERVICE->IDLE transition.
REQ-025 MODE changes SHALL clear the affected PENDING bit in the same cycle.

Reset
REQ-026 On reset the block SHALL set: PENDING=0, MASK=0, MODE=0, CAUSE=0, synchronizer and edge flops=0, FSM=IDLE, interrupt=0.
REQ-027 Reset asserted mid-REQ or mid-SERVICE SHALL drop interrupt at the same posedge, with no request retained.

Structure
REQ-028 Package tiny16_intc_pkg SHALL hold the register offsets (OFS_PENDING=0, OFS_MASK=1, OFS_CAUSE=2, OFS_MODE=3), the FSM state typedef and the default BASE.
REQ-029 The per-line synchronizer and edge detector SHALL be one sub-module, tiny16_irq_sync, instantiated 8 times.

Verification
REQ-030 MASK=0x01, MODE=0x01, pulse irq[0] for 1 cycle before posedge k -> PENDING=0x01 at k+2, interrupt=1 at k+3; raise in_interrupt -> CAUSE=0x8000, PENDING=0x00, interrupt=0.
REQ-031 MASK=0xFF, MODE=0xFF, irq[5] and irq[2] rise in the same cycle -> CAUSE=0x8002 at service entry, PENDING=0x20; after in_interrupt falls, interrupt re-asserts and CAUSE=0x8005 at the next service entry.
REQ-032 MODE=0x00, MASK=0x08, hold irq[3]=1 -> interrupt=1; write PENDING=0x08 -> PENDING stays 0x08; drop irq[3] -> PENDING=0 and interrupt=0 (REQ->IDLE).
REQ-033 Edge on irq[1] in the same cycle as a W1C write of 0x02 -> PENDING bit 1 remains set.
REQ-034 While in REQ, write MASK=0 -> interrupt=0 the next cycle; assert reset during SERVICE -> all registers read 0 and interrupt=0.
REQ-035 Read BASE+4 with rd=0 -> sel=0 and data_out=0x0000; read BASE+1 after writing 0xABCD -> data_out=0x00CD.
